// File: rtl/rv32e_rf_ctrl_if.sv
// Debug access bus between an external debug host and the RV32E register-file controller.
// Latency: none (signal bundle only).
// Backpressure: dbg_req is a level held by the host until the one-cycle dbg_ack pulse.
// Ports: master = debug host (drives req/wr/addr/wdata), slave = controller (drives ack/rdata).
interface rv32e_rf_ctrl_if;
    logic        dbg_req;
    logic        dbg_wr;
    logic [3:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;

    modport master (
        output dbg_req, dbg_wr, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata
    );

    modport slave (
        input  dbg_req, dbg_wr, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata
    );
endinterface

// File: rtl/rv32e_rf_ctrl.sv
// Arbitrates the RV32E register-file write/read-1 ports between core writeback, debug access and a bulk clear.
// Latency: debug access acks 2 cycles after grant (DBG, ACK); clear runs exactly 15 cycles.
// Backpressure: core_stall holds the core during CLEAR/DBG; a waiting debug request forces a grant after STARVE_LIMIT blocked cycles.
// Ports: clk/rst_n; dbg (slave modport of rv32e_rf_ctrl_if); core_* writeback + rs1 address in, core_stall out;
//        clr_start in / clr_busy out; rf_* write port and rs1 read port towards the register file.
module rv32e_rf_ctrl #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rv32e_rf_ctrl_if.slave       dbg,
    input  logic                 core_we_i,
    input  logic [3:0]           core_waddr_i,
    input  logic [31:0]          core_wdata_i,
    input  logic [3:0]           core_rs1_addr_i,
    output logic                 core_stall_o,
    input  logic                 clr_start_i,
    output logic                 clr_busy_o,
    output logic                 rf_we_o,
    output logic [3:0]           rf_waddr_o,
    output logic [31:0]          rf_wdata_o,
    output logic [3:0]           rf_rs1_addr_o,
    input  logic [31:0]          rf_rs1_data_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DBG   = 2'd2,
        ST_ACK   = 2'd3
    } state_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_e      state_q;
    logic [3:0]  clr_cnt_q;
    logic [3:0]  starve_cnt_q;
    logic        dbg_ack_q;
    logic [31:0] dbg_rdata_q;
    logic        clr_busy_q;

    // Debug wins the port either when the core is not writing this cycle
    // or when it has already been held off for STARVE_LIMIT cycles.
    logic dbg_grant;
    assign dbg_grant = dbg.dbg_req && (!core_we_i || (starve_cnt_q == LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            clr_cnt_q    <= 4'd0;
            starve_cnt_q <= 4'd0;
            dbg_ack_q    <= 1'b0;
            dbg_rdata_q  <= 32'd0;
            clr_busy_q   <= 1'b0;
        end else begin
            dbg_ack_q <= 1'b0;
            // A withdrawn request forgets any accumulated waiting time.
            if (!dbg.dbg_req) begin
                starve_cnt_q <= 4'd0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (clr_start_i) begin
                        state_q    <= ST_CLEAR;
                        clr_cnt_q  <= 4'd1;
                        clr_busy_q <= 1'b1;
                    end else if (dbg_grant) begin
                        state_q      <= ST_DBG;
                        starve_cnt_q <= 4'd0;
                    end else if (dbg.dbg_req && core_we_i && (starve_cnt_q != LIMIT)) begin
                        starve_cnt_q <= starve_cnt_q + 4'd1;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt_q == 4'd15) begin
                        state_q    <= ST_IDLE;
                        clr_cnt_q  <= 4'd0;
                        clr_busy_q <= 1'b0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 4'd1;
                    end
                end
                ST_DBG: begin
                    dbg_rdata_q <= rf_rs1_data_i;
                    dbg_ack_q   <= 1'b1;
                    state_q     <= ST_ACK;
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Register-file port steering; IDLE and ACK pass the core straight through.
    always_comb begin
        rf_we_o       = core_we_i;
        rf_waddr_o    = core_waddr_i;
        rf_wdata_o    = core_wdata_i;
        rf_rs1_addr_o = core_rs1_addr_i;
        core_stall_o  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                rf_we_o      = 1'b1;
                rf_waddr_o   = clr_cnt_q;
                rf_wdata_o   = 32'd0;
                core_stall_o = 1'b1;
            end
            ST_DBG: begin
                rf_we_o       = dbg.dbg_wr;
                rf_waddr_o    = dbg.dbg_addr;
                rf_wdata_o    = dbg.dbg_wdata;
                rf_rs1_addr_o = dbg.dbg_addr;
                core_stall_o  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign dbg.dbg_ack   = dbg_ack_q;
    assign dbg.dbg_rdata = dbg_rdata_q;
    assign clr_busy_o    = clr_busy_q;

endmodule

// File: tb/tb_rv32e_rf_ctrl.sv
module tb_rv32e_rf_ctrl;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_we = 1'b0;
    logic [3:0]  core_waddr = 4'd0;
    logic [31:0] core_wdata = 32'd0;
    logic [3:0]  core_rs1_addr = 4'd0;
    logic        core_stall;
    logic        clr_start = 1'b0;
    logic        clr_busy;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [3:0]  rf_rs1_addr;
    logic [31:0] rf_rs1_data;
    logic        env_init = 1'b1;

    always #5 clk = ~clk;

    rv32e_rf_ctrl_if dbg_if ();

    rv32e_rf_ctrl #(.STARVE_LIMIT(LIMIT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .dbg             (dbg_if.slave),
        .core_we_i       (core_we),
        .core_waddr_i    (core_waddr),
        .core_wdata_i    (core_wdata),
        .core_rs1_addr_i (core_rs1_addr),
        .core_stall_o    (core_stall),
        .clr_start_i     (clr_start),
        .clr_busy_o      (clr_busy),
        .rf_we_o         (rf_we),
        .rf_waddr_o      (rf_waddr),
        .rf_wdata_o      (rf_wdata),
        .rf_rs1_addr_o   (rf_rs1_addr),
        .rf_rs1_data_i   (rf_rs1_data)
    );

    // Environment register file driven by the DUT's rf_* ports; x0 reads as zero.
    logic [31:0] env_rf [16];
    always @(posedge clk) begin
        if (env_init) begin
            for (int i = 0; i < 16; i++) env_rf[i] <= 32'd0;
        end else if (rf_we) begin
            env_rf[rf_waddr] <= rf_wdata;
        end
    end
    assign rf_rs1_data = (rf_rs1_addr == 4'd0) ? 32'd0 : env_rf[rf_rs1_addr];

    // Reference model: architectural register contents as the spec says they should be.
    logic [31:0] ref_rf [16];

    typedef struct {
        logic        is_rd;
        logic [31:0] data;
        string       name;
    } exp_t;
    exp_t exp_q [$];

    int vectors = 0;
    int miscompares = 0;
    int ack_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every ack pops one expected response.
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n && dbg_if.dbg_ack) begin
            ack_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.name, "_stall_in_ack"}, {31'd0, core_stall}, 32'd0);
                if (mon_e.is_rd) check({mon_e.name, "_rdata"}, dbg_if.dbg_rdata, mon_e.data);
            end
        end
    end

    task automatic dbg_issue(input logic wr, input logic [3:0] a, input logic [31:0] d, input string nm);
        exp_t e;
        e.is_rd = !wr;
        e.data  = (a == 4'd0) ? 32'd0 : ref_rf[a];
        e.name  = nm;
        exp_q.push_back(e);
        if (wr && a != 4'd0) ref_rf[a] = d;
        dbg_if.dbg_req   = 1'b1;
        dbg_if.dbg_wr    = wr;
        dbg_if.dbg_addr  = a;
        dbg_if.dbg_wdata = d;
    endtask

    task automatic dbg_wait_ack(input string nm, output int cycles);
        int n;
        for (n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (dbg_if.dbg_ack) break;
        end
        if (n > 200) check({nm, "_ack_timeout"}, 32'd0, 32'd1);
        cycles = n;
        dbg_if.dbg_req = 1'b0;
    endtask

    task automatic dbg_op(input logic wr, input logic [3:0] a, input logic [31:0] d, input string nm);
        int n;
        @(negedge clk);
        dbg_issue(wr, a, d, nm);
        dbg_wait_ack(nm, n);
    endtask

    task automatic read_sweep(input string nm);
        for (int a = 0; a < 16; a++) dbg_op(1'b0, 4'(a), 32'd0, nm);
    endtask

    task automatic preload_all();
        for (int a = 1; a < 16; a++) dbg_op(1'b1, 4'(a), $urandom | 32'h1, "preload");
    endtask

    // Core model: picks random writebacks to x1..x7, holding each one while stalled.
    task automatic core_driver(input int ncyc);
        logic pend;
        pend = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (!pend) begin
                core_we    = 1'($urandom_range(0, 1));
                core_waddr = 4'($urandom_range(1, 7));
                core_wdata = $urandom;
            end
            if (core_we && !core_stall) begin
                ref_rf[core_waddr] = core_wdata;
                pend = 1'b0;
            end else begin
                pend = core_we;
            end
        end
        @(negedge clk);
        if (pend && !core_stall) ref_rf[core_waddr] = core_wdata;
        core_we = 1'b0;
    endtask

    task automatic starve_measure(input string nm);
        int waits;
        int n;
        @(negedge clk);
        core_we    = 1'b1;
        core_waddr = 4'd1;
        core_wdata = 32'hA5A5_0001;
        ref_rf[1]  = 32'hA5A5_0001;
        dbg_issue(1'b0, 4'd9, 32'd0, nm);
        waits = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (core_stall) break;
            waits++;
        end
        check({nm, "_waits"}, 32'(waits), 32'(LIMIT));
        dbg_wait_ack(nm, n);
        check({nm, "_ack_latency"}, 32'(n), 32'd1);
        core_we = 1'b0;
    endtask

    initial begin
        int n;
        int a0;
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int a0;
        dbg_if.dbg_req   = 1'b0;
        dbg_if.dbg_wr    = 1'b0;
        dbg_if.dbg_addr  = 4'd0;
        dbg_if.dbg_wdata = 32'd0;
        for (int i = 0; i < 16; i++) ref_rf[i] = 32'd0;
        repeat (3) @(negedge clk);
        env_init = 1'b0;

        // Reset state
        check("rst_dbg_ack", {31'd0, dbg_if.dbg_ack}, 32'd0);
        check("rst_dbg_rdata", dbg_if.dbg_rdata, 32'd0);
        check("rst_clr_busy", {31'd0, clr_busy}, 32'd0);
        check("rst_core_stall", {31'd0, core_stall}, 32'd0);
        check("rst_rf_we", {31'd0, rf_we}, 32'd0);
        rst_n = 1'b1;

        // Core passthrough in IDLE
        @(negedge clk);
        core_we = 1'b1; core_waddr = 4'd2; core_wdata = 32'h1234_5678; core_rs1_addr = 4'd2;
        ref_rf[2] = 32'h1234_5678;
        #1;
        check("idle_rf_we", {31'd0, rf_we}, 32'd1);
        check("idle_rf_waddr", {28'd0, rf_waddr}, 32'd2);
        check("idle_rf_wdata", rf_wdata, 32'h1234_5678);
        check("idle_rf_rs1_addr", {28'd0, rf_rs1_addr}, 32'd2);
        @(negedge clk);
        core_we = 1'b0;

        // Debug write x5, then read it back
        dbg_issue(1'b1, 4'd5, 32'hDEAD_BEEF, "wr_x5");
        @(negedge clk);
        check("wr_x5_stall", {31'd0, core_stall}, 32'd1);
        check("wr_x5_rf_we", {31'd0, rf_we}, 32'd1);
        check("wr_x5_waddr", {28'd0, rf_waddr}, 32'd5);
        check("wr_x5_wdata", rf_wdata, 32'hDEAD_BEEF);
        check("wr_x5_rs1_addr", {28'd0, rf_rs1_addr}, 32'd5);
        dbg_wait_ack("wr_x5", n);
        check("wr_x5_ack_latency", 32'(n), 32'd1);
        dbg_op(1'b0, 4'd5, 32'd0, "rd_x5");
        dbg_op(1'b0, 4'd2, 32'd0, "rd_x2");

        // x0: read returns zero, write is issued and acked
        dbg_op(1'b0, 4'd0, 32'd0, "rd_x0");
        @(negedge clk);
        dbg_issue(1'b1, 4'd0, 32'h5555_5555, "wr_x0");
        @(negedge clk);
        check("wr_x0_rf_we", {31'd0, rf_we}, 32'd1);
        check("wr_x0_waddr", {28'd0, rf_waddr}, 32'd0);
        dbg_wait_ack("wr_x0", n);
        dbg_op(1'b0, 4'd0, 32'd0, "rd_x0_after_wr");

        // Starvation: forced grant after LIMIT blocked cycles
        starve_measure("starve");

        // Request withdrawn before grant: no ack, counter forgotten
        @(negedge clk);
        core_we = 1'b1; core_waddr = 4'd1; core_wdata = 32'hA5A5_0001;
        a0 = ack_seen;
        dbg_if.dbg_req = 1'b1; dbg_if.dbg_wr = 1'b0; dbg_if.dbg_addr = 4'd10;
        repeat (5) @(negedge clk);
        dbg_if.dbg_req = 1'b0;
        repeat (3) @(negedge clk);
        core_we = 1'b0;
        repeat (12) @(negedge clk);
        check("dropped_no_ack", 32'(ack_seen), 32'(a0));
        starve_measure("starve_after_drop");

        // Bulk clear; a second clr_start mid-sequence must be ignored
        preload_all();
        @(negedge clk);
        clr_start = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            clr_start = (i == 5);
            check($sformatf("clr%0d_busy", i), {31'd0, clr_busy}, 32'd1);
            check($sformatf("clr%0d_we", i), {31'd0, rf_we}, 32'd1);
            check($sformatf("clr%0d_waddr", i), {28'd0, rf_waddr}, 32'(i));
            check($sformatf("clr%0d_wdata", i), rf_wdata, 32'd0);
            check($sformatf("clr%0d_stall", i), {31'd0, core_stall}, 32'd1);
        end
        clr_start = 1'b0;
        @(negedge clk);
        check("clr_done_busy", {31'd0, clr_busy}, 32'd0);
        check("clr_done_stall", {31'd0, core_stall}, 32'd0);
        for (int i = 1; i < 16; i++) ref_rf[i] = 32'd0;
        read_sweep("after_clr");

        // clr_start and dbg_req together: clear first, then the debug read
        dbg_op(1'b1, 4'd3, 32'h0BAD_F00D, "wr_x3");
        @(negedge clk);
        clr_start = 1'b1;
        for (int i = 1; i < 16; i++) ref_rf[i] = 32'd0;
        dbg_issue(1'b0, 4'd3, 32'd0, "clr_then_rd");
        @(negedge clk);
        clr_start = 1'b0;
        check("clr_first_busy", {31'd0, clr_busy}, 32'd1);
        dbg_wait_ack("clr_then_rd", n);
        check("clr_then_rd_latency", 32'(n + 1), 32'd18);

        // Reset during clear cycle 7
        preload_all();
        @(negedge clk);
        clr_start = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            clr_start = 1'b0;
        end
        check("abort_waddr", {28'd0, rf_waddr}, 32'd7);
        rst_n = 1'b0;
        #1;
        check("abort_clr_busy", {31'd0, clr_busy}, 32'd0);
        check("abort_stall", {31'd0, core_stall}, 32'd0);
        check("abort_rf_we", {31'd0, rf_we}, 32'd0);
        for (int i = 1; i <= 6; i++) ref_rf[i] = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        read_sweep("after_abort");

        // Random traffic: core on x1..x7, debug on x0/x8..x15
        fork
            core_driver(400);
            begin
                for (int k = 0; k < 40; k++) begin
                    int r;
                    r = $urandom_range(7, 15);
                    dbg_op(1'($urandom_range(0, 1)), (r == 7) ? 4'd0 : 4'(r), $urandom, "rand");
                end
            end
        join
        read_sweep("final");

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rv32e_rf_ctrl.md
RV32E_RF_CTRL -- requirements
Module: rv32e_rf_ctrl

Interface
REQ-001 Parameter: STARVE_LIMIT, default 8, max cycles a pending debug request waits on core write traffic before forced grant (range 1..15).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 core_we / core_waddr / core_wdata  input  1/4/32  core writeback request.
REQ-005 core_rs1_addr  input  4  core read-port-1 address.
REQ-006 core_stall  output  1  core holds its pipeline, including the pending writeback, while high.
REQ-007 dbg_req / dbg_wr / dbg_addr / dbg_wdata  input  1/1/4/32  debug access request (level, held until ack), 1=write 0=read, register index, write data.
REQ-008 dbg_ack  output  1  one-cycle completion pulse; dbg_rdata  output  32  read result, valid while dbg_ack=1.
REQ-009 clr_start  input  1  single-cycle request to zero x1..x15; clr_busy  output  1  clear sequence active.
REQ-010 rf_we / rf_waddr / rf_wdata  output  1/4/32  register-file write port.
REQ-011 rf_rs1_addr  output  4  register-file read-port-1 address; rf_rs1_data  input  32  register-file read-port-1 data.

Function
REQ-012 FSM states: IDLE, CLEAR, DBG, ACK; one state per cycle.
REQ-013 IDLE: rf_we/waddr/wdata = core_we/core_waddr/core_wdata; rf_rs1_addr=core_rs1_addr; core_stall=0.
REQ-014 IDLE->CLEAR when clr_start=1; clr_start wins over dbg_req in the same cycle; clr_start ignored in every other state.
REQ-015 CLEAR: clear counter starts at 1; each cycle rf_we=1, rf_waddr=counter, rf_wdata=0, core_stall=1, clr_busy=1; counter increments; after writing index 15 -> IDLE; exactly 15 cycles, x0 never written.
REQ-016 Starvation counter: in IDLE, increments each cycle dbg_req=1 and core_we=1, saturating at STARVE_LIMIT; cleared when dbg_req=0 or on DBG entry.
REQ-017 IDLE->DBG when dbg_req=1, clr_start=0, and (core_we=0 or starvation counter==STARVE_LIMIT); core write present in that IDLE cycle completes normally.
REQ-018 DBG (1 cycle): core_stall=1; rf_rs1_addr=dbg_addr; rf_we=dbg_wr, rf_waddr=dbg_addr, rf_wdata=dbg_wdata; dbg_rdata registered from rf_rs1_data at cycle end; -> ACK.
REQ-019 ACK (1 cycle): dbg_ack=1, dbg_rdata held; core path as IDLE, core_stall=0; no new DBG or CLEAR entry; -> IDLE.
REQ-020 Debug read of x0 returns 0 (register file behaviour); debug write to x0 issues rf_we=1 with waddr=0 and is acknowledged normally.
REQ-021 dbg_req deasserted before grant: no access, no ack, counter cleared.
REQ-022 Debug read of a register the core writes in the DBG cycle is impossible (core stalled); read reflects all writes completed before DBG.
REQ-023 rf_* and core_stall combinational from state and inputs; dbg_ack, dbg_rdata, clr_busy, counters registered.

Reset
REQ-024 On rst_n=0, asynchronously: state=IDLE, both counters=0, dbg_ack=0, dbg_rdata=0, clr_busy=0; rf_we and core_stall then follow IDLE rules.
REQ-025 Reset during CLEAR or DBG aborts the operation; partially cleared registers are not restored; no ack issued.

Verification
REQ-026 Debug write x5=0xDEADBEEF with core_we=0 -> DBG next cycle, rf_we=1 waddr=5, ack next cycle; debug read x5 then returns 0xDEADBEEF.
REQ-027 dbg_req with core_we=1 continuously, STARVE_LIMIT=8 -> grant after exactly 8 waiting cycles; core_stall=1 only in DBG cycle.
REQ-028 Preload x1..x15 nonzero, pulse clr_start -> clr_busy high 15 cycles, waddr 1..15 in order, data 0; all reads return 0 afterwards.
REQ-029 clr_start and dbg_req in same cycle -> CLEAR first, then DBG; debug access completes after clear.
REQ-030 Assert rst_n=0 at clear cycle 7 -> clr_busy=0 immediately, x1..x6 zero, x7..x15 retain old values, state IDLE.
REQ-031 Debug read x0 -> dbg_rdata=0x00000000 with ack; dbg_req dropped before grant -> no ack.
